// File: rtl/sensor_word_scheduler.sv
// rtl/sensor_word_scheduler.sv - round-robin scheduler of per-sensor shadow words onto one tagged valid/ready stream
module sensor_word_scheduler #(
  parameter int NUMBER_OF_SENSORS = 20,
  parameter int ID_WIDTH          = 5,
  parameter int OVR_WIDTH         = 16
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic                            enable_i,
  input  logic [32*NUMBER_OF_SENSORS-1:0] sensor_data_i,
  input  logic [NUMBER_OF_SENSORS-1:0]    sensor_valid_i,
  output logic                            out_valid_o,
  input  logic                            out_ready_i,
  output logic [31:0]                     out_data_o,
  output logic [ID_WIDTH-1:0]             out_sensor_id_o,
  output logic [NUMBER_OF_SENSORS-1:0]    pending_o,
  output logic [OVR_WIDTH-1:0]            overrun_cnt_o,
  input  logic                            overrun_clr_i
);

  localparam int N = NUMBER_OF_SENSORS;

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t              state;
  logic [31:0]         shadow [N];
  logic [ID_WIDTH-1:0] rr_ptr;
  logic [ID_WIDTH-1:0] grant_idx;
  logic [N-1:0]        cand_hi;
  logic [N-1:0]        cand;
  logic [N-1:0]        grant_onehot;
  logic [N-1:0]        overrun_vec;
  logic [5:0]          overrun_num;
  logic [OVR_WIDTH:0]  ovr_sum;
  logic                grant_en;

  // Pick the first pending slot strictly after rr_ptr, wrapping to the lowest pending slot.
  always_comb begin
    cand_hi   = '0;
    grant_idx = '0;
    for (int i = 0; i < N; i++) begin
      cand_hi[i] = pending_o[i] && (ID_WIDTH'(i) > rr_ptr);
    end
    cand = (|cand_hi) ? cand_hi : pending_o;
    for (int i = N - 1; i >= 0; i--) begin
      if (cand[i]) grant_idx = ID_WIDTH'(i);
    end
  end

  // A new word may start from IDLE, or in PRESENT only on the cycle the current word is accepted.
  always_comb begin
    grant_en = enable_i && (|pending_o) && ((state == IDLE) || out_ready_i);
    for (int i = 0; i < N; i++) begin
      grant_onehot[i] = grant_en && (grant_idx == ID_WIDTH'(i));
    end
    // A word being granted this cycle is not lost, so a strobe on that slot is not an overrun.
    overrun_vec = sensor_valid_i & pending_o & ~grant_onehot;
    overrun_num = '0;
    for (int i = 0; i < N; i++) begin
      overrun_num = overrun_num + 6'(overrun_vec[i]);
    end
    ovr_sum = {1'b0, overrun_cnt_o} + (OVR_WIDTH + 1)'(overrun_num);
  end

  // Capture strobed words into their shadow slots; granted slots clear unless re-strobed.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) shadow[i] <= '0;
      pending_o <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (sensor_valid_i[i]) shadow[i] <= sensor_data_i[32*i +: 32];
      end
      pending_o <= (pending_o & ~grant_onehot) | sensor_valid_i;
    end
  end

  // Saturating overrun counter; clear wins over a same-cycle increment.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      overrun_cnt_o <= '0;
    end else if (overrun_clr_i) begin
      overrun_cnt_o <= '0;
    end else if (ovr_sum[OVR_WIDTH]) begin
      overrun_cnt_o <= '1;
    end else begin
      overrun_cnt_o <= ovr_sum[OVR_WIDTH-1:0];
    end
  end

  // Output FSM: a grant loads the output register (pre-strobe shadow value) and moves rr_ptr.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      out_valid_o     <= 1'b0;
      out_data_o      <= '0;
      out_sensor_id_o <= '0;
      rr_ptr          <= ID_WIDTH'(N - 1);
    end else begin
      case (state)
        IDLE: begin
          if (grant_en) begin
            state           <= PRESENT;
            out_valid_o     <= 1'b1;
            out_data_o      <= shadow[grant_idx];
            out_sensor_id_o <= grant_idx;
            rr_ptr          <= grant_idx;
          end
        end
        PRESENT: begin
          if (grant_en) begin
            out_data_o      <= shadow[grant_idx];
            out_sensor_id_o <= grant_idx;
            rr_ptr          <= grant_idx;
          end else if (out_ready_i) begin
            state       <= IDLE;
            out_valid_o <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          out_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
